// File: rtl/logic_cell_array_pkg.sv
// Shared definitions for the logic cell array: mode codes, their limits and
// the small pure helpers used by each cell and by the load decoder.
package logic_cell_array_pkg;

    localparam int MODE_W = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_AND  = 4'd0,
        MODE_OR   = 4'd1,
        MODE_NAND = 4'd2,
        MODE_NOR  = 4'd3,
        MODE_XOR  = 4'd4,
        MODE_XNOR = 4'd5,
        MODE_SR   = 4'd6,
        MODE_T    = 4'd7,
        MODE_D    = 4'd8,
        MODE_JK   = 4'd9
    } cell_mode_e;

    // Highest code a cell may be loaded with; everything above is rejected.
    localparam logic [MODE_W-1:0] MODE_MAX = 4'd9;

    // True when the code names one of the ten implemented cell behaviours.
    function automatic logic code_is_valid(input logic [MODE_W-1:0] code);
        return code <= MODE_MAX;
    endfunction

    // Combinational gate result for the six gate modes; storage modes give 0.
    function automatic logic gate_eval(input cell_mode_e m, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (m)
            MODE_AND:  r = a & b;
            MODE_OR:   r = a | b;
            MODE_NAND: r = ~(a & b);
            MODE_NOR:  r = ~(a | b);
            MODE_XOR:  r = a ^ b;
            MODE_XNOR: r = ~(a ^ b);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_cell_array_cell.sv
// One logic cell: run-time mode register, storage bit q, previous b for
// edge detection in T mode, and the registered output y.
module logic_cell
    import logic_cell_array_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              load,
    input  logic [MODE_W-1:0] code,
    input  logic              a,
    input  logic              b,
    output logic              y,
    output logic [MODE_W-1:0] mode
);

    cell_mode_e mode_q;
    logic       q_q;
    logic       q_d;
    logic       y_q;
    logic       y_d;
    logic       b_prev_q;
    logic       b_rise;

    assign b_rise = b & ~b_prev_q;

    // Next q/y for the current mode; storage modes mirror q onto y.
    always_comb begin
        q_d = q_q;
        y_d = y_q;
        case (mode_q)
            MODE_AND, MODE_OR, MODE_NAND, MODE_NOR, MODE_XOR, MODE_XNOR: begin
                y_d = gate_eval(mode_q, a, b);
            end
            MODE_SR: begin
                if (b) begin
                    q_d = 1'b0;
                end else if (a) begin
                    q_d = 1'b1;
                end
                y_d = q_d;
            end
            MODE_T: begin
                if (a && b_rise) begin
                    q_d = ~q_q;
                end
                y_d = q_d;
            end
            MODE_D: begin
                if (b) begin
                    q_d = a;
                end
                y_d = q_d;
            end
            MODE_JK: begin
                case ({a, b})
                    2'b10:   q_d = 1'b1;
                    2'b01:   q_d = 1'b0;
                    2'b11:   q_d = ~q_q;
                    default: q_d = q_q;
                endcase
                y_d = q_d;
            end
            default: begin
                q_d = q_q;
                y_d = y_q;
            end
        endcase
    end

    // A load restarts the cell regardless of en; b history tracks every cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mode_q   <= MODE_AND;
            q_q      <= 1'b0;
            y_q      <= 1'b0;
            b_prev_q <= 1'b0;
        end else begin
            b_prev_q <= b;
            if (load) begin
                mode_q <= cell_mode_e'(code);
                q_q    <= 1'b0;
                y_q    <= 1'b0;
            end else if (en) begin
                q_q <= q_d;
                y_q <= y_d;
            end
        end
    end

    assign y    = y_q;
    assign mode = mode_q;

endmodule

// File: rtl/logic_cell_array.sv
// Array of independent logic cells with a shared mode-load port; bad loads
// are dropped and flagged with a one-cycle sel_err pulse.
module logic_cell_array
    import logic_cell_array_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       en,
    input  logic                       sel_load,
    input  logic [CH_W-1:0]            sel_chan,
    input  logic [MODE_W-1:0]          sel_code,
    input  logic [CHANNELS-1:0]        a,
    input  logic [CHANNELS-1:0]        b,
    output logic [CHANNELS-1:0]        y,
    output logic [MODE_W*CHANNELS-1:0] mode_q,
    output logic                       sel_err
);

    logic [CHANNELS-1:0] chan_hit;
    logic [CHANNELS-1:0] cell_load;
    logic                chan_ok;
    logic                load_ok;
    logic                sel_err_q;
    logic                sel_err_d;

    // The channel is valid only if it matches one of the instantiated cells,
    // which avoids comparing against a constant range.
    assign chan_ok   = |chan_hit;
    assign load_ok   = sel_load & chan_ok & code_is_valid(sel_code);
    assign sel_err_d = sel_load & ~load_ok;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_cell
            assign chan_hit[i]  = (sel_chan == CH_W'(i));
            assign cell_load[i] = load_ok & chan_hit[i];

            logic_cell u_cell (
                .clk    (clk),
                .resetn (resetn),
                .en     (en),
                .load   (cell_load[i]),
                .code   (sel_code),
                .a      (a[i]),
                .b      (b[i]),
                .y      (y[i]),
                .mode   (mode_q[MODE_W*i +: MODE_W])
            );
        end
    endgenerate

    // Rejected loads produce exactly one cycle of sel_err.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_logic_cell_array.sv
// Self-checking bench for logic_cell_array: a reference model pushes expected
// outputs into a scoreboard on each driven cycle; tests pop and compare.
module tb_logic_cell_array;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic        sel_load;
    logic        sel_load3;
    logic [1:0]  sel_chan;
    logic [3:0]  sel_code;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  y;
    logic [15:0] mode_q;
    logic        sel_err;
    logic [2:0]  y3;
    logic [11:0] mode_q3;
    logic        sel_err3;

    always #5 clk = ~clk;

    logic_cell_array #(.CHANNELS(4), .CH_W(2)) dut (
        .clk(clk), .resetn(resetn), .en(en), .sel_load(sel_load),
        .sel_chan(sel_chan), .sel_code(sel_code), .a(a), .b(b),
        .y(y), .mode_q(mode_q), .sel_err(sel_err)
    );

    logic_cell_array #(.CHANNELS(3), .CH_W(2)) dut3 (
        .clk(clk), .resetn(resetn), .en(en), .sel_load(sel_load3),
        .sel_chan(sel_chan), .sel_code(sel_code), .a(a[2:0]), .b(b[2:0]),
        .y(y3), .mode_q(mode_q3), .sel_err(sel_err3)
    );

    typedef struct packed {
        logic [3:0]  y;
        logic [15:0] mode;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t exp_v;
    int   checks   = 0;
    int   failures = 0;

    // Gate truth tables indexed by {a,b}.
    logic [3:0] TT [6];
    initial begin
        TT[0] = 4'b1000;
        TT[1] = 4'b1110;
        TT[2] = 4'b0111;
        TT[3] = 4'b0001;
        TT[4] = 4'b0110;
        TT[5] = 4'b1001;
    end

    logic [3:0] m_mode [4];
    logic       m_q    [4];
    logic       m_y    [4];
    logic       m_bp   [4];

    // Drive one cycle, advance the model, push the expectation, step past the edge.
    task automatic step(input logic rn, input logic e, input logic ld, input logic [1:0] ch,
                        input logic [3:0] code, input logic [3:0] av, input logic [3:0] bv);
        exp_t  ex;
        logic  valid;
        logic  nq;
        logic  ny;
        resetn   = rn;
        en       = e;
        sel_load = ld;
        sel_chan = ch;
        sel_code = code;
        a        = av;
        b        = bv;
        valid    = ld && (code <= 4'd9);
        for (int i = 0; i < 4; i++) begin
            if (!rn) begin
                m_mode[i] = 4'd0; m_q[i] = 1'b0; m_y[i] = 1'b0; m_bp[i] = 1'b0;
            end else begin
                nq = m_q[i];
                ny = m_y[i];
                if (valid && ch == 2'(i)) begin
                    m_mode[i] = code; nq = 1'b0; ny = 1'b0;
                end else if (e) begin
                    if (m_mode[i] <= 4'd5) begin
                        ny = TT[m_mode[i]][{av[i], bv[i]}];
                    end else begin
                        case (m_mode[i])
                            4'd6: if (bv[i]) nq = 1'b0; else if (av[i]) nq = 1'b1;
                            4'd7: if (av[i] && bv[i] && !m_bp[i]) nq = ~nq;
                            4'd8: if (bv[i]) nq = av[i];
                            4'd9: begin
                                if (av[i] && bv[i]) nq = ~nq;
                                else if (av[i]) nq = 1'b1;
                                else if (bv[i]) nq = 1'b0;
                            end
                            default: ;
                        endcase
                        ny = nq;
                    end
                end
                m_q[i]  = nq;
                m_y[i]  = ny;
                m_bp[i] = bv[i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            ex.y[i]          = m_y[i];
            ex.mode[4*i +: 4] = m_mode[i];
        end
        ex.err = rn && ld && !valid;
        sb.push_back(ex);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 4'hF, 4'hF);
            exp_v = sb.pop_front();
            checks++;
            if (y !== exp_v.y || mode_q !== exp_v.mode || sel_err !== exp_v.err) begin
                failures++;
                $display("[TB] FAIL reset_model y=%h/%h mode=%h/%h err=%b/%b", y, exp_v.y, mode_q, exp_v.mode, sel_err, exp_v.err);
            end
            checks++;
            if (y !== 4'h0 || mode_q !== 16'h0 || sel_err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_zero y=%h mode=%h err=%b want 0", y, mode_q, sel_err);
            end
        end
        step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'hF, 4'hF);
        exp_v = sb.pop_front();
        checks++;
        if (y !== exp_v.y || y !== 4'hF) begin
            failures++;
            $display("[TB] FAIL reset_release_and y=%h want %h", y, exp_v.y);
        end
    endtask

    task automatic test_gate_sweep();
        for (int code = 0; code < 6; code++) begin
            step(1'b1, 1'b1, 1'b1, 2'd0, 4'(code), 4'h0, 4'h0);
            exp_v = sb.pop_front();
            checks++;
            if (y !== exp_v.y || mode_q !== exp_v.mode || mode_q[3:0] !== 4'(code)) begin
                failures++;
                $display("[TB] FAIL gate_load code=%0d y=%h/%h mode=%h/%h", code, y, exp_v.y, mode_q, exp_v.mode);
            end
            for (int ab = 0; ab < 4; ab++) begin
                step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, {3'b0, 1'(ab >> 1)}, {3'b0, 1'(ab)});
                exp_v = sb.pop_front();
                checks++;
                if (y !== exp_v.y || y[0] !== TT[code][ab] || y[3:1] !== 3'b000) begin
                    failures++;
                    $display("[TB] FAIL gate code=%0d ab=%0d y=%h want %h", code, ab, y, exp_v.y);
                end
            end
        end
    endtask

    task automatic test_sr_t();
        logic [3:0] sa [5];
        logic [3:0] sbv [5];
        logic       sy [5];
        step(1'b1, 1'b1, 1'b1, 2'd2, 4'd6, 4'h0, 4'h0);
        sa[0] = 4'h4; sbv[0] = 4'h0; sy[0] = 1'b1;
        sa[1] = 4'h0; sbv[1] = 4'h0; sy[1] = 1'b1;
        sa[2] = 4'h4; sbv[2] = 4'h4; sy[2] = 1'b0;
        exp_v = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, sa[k], sbv[k]);
            exp_v = sb.pop_front();
            checks++;
            if (y !== exp_v.y || y[2] !== sy[k]) begin
                failures++;
                $display("[TB] FAIL sr step=%0d y=%h want %h y2 want %b", k, y, exp_v.y, sy[k]);
            end
        end
        step(1'b1, 1'b1, 1'b1, 2'd2, 4'd7, 4'h0, 4'h0);
        exp_v = sb.pop_front();
        sbv[0] = 4'h4; sy[0] = 1'b1;
        sbv[1] = 4'h0; sy[1] = 1'b1;
        sbv[2] = 4'h4; sy[2] = 1'b0;
        sbv[3] = 4'h0; sy[3] = 1'b0;
        sbv[4] = 4'h4; sy[4] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'h4, (k < 5) ? sbv[k] : 4'h4);
            exp_v = sb.pop_front();
            checks++;
            if (y !== exp_v.y || y[2] !== ((k < 5) ? sy[k] : 1'b1)) begin
                failures++;
                $display("[TB] FAIL toggle step=%0d y=%h want %h", k, y, exp_v.y);
            end
        end
    endtask

    task automatic test_d_jk();
        step(1'b1, 1'b1, 1'b1, 2'd3, 4'd8, 4'h0, 4'h0);
        exp_v = sb.pop_front();
        step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'h8, 4'h8);
        exp_v = sb.pop_front();
        checks++;
        if (y !== exp_v.y || y[3] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL d_capture y=%h want %h", y, exp_v.y);
        end
        step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'h0, 4'h0);
        exp_v = sb.pop_front();
        checks++;
        if (y !== exp_v.y || y[3] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL d_hold y=%h want %h", y, exp_v.y);
        end
        step(1'b1, 1'b1, 1'b1, 2'd3, 4'd9, 4'h0, 4'h0);
        exp_v = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'h8, 4'h8);
            exp_v = sb.pop_front();
            checks++;
            if (y !== exp_v.y || y[3] !== ((k % 2) == 0)) begin
                failures++;
                $display("[TB] FAIL jk_toggle step=%0d y=%h want %h", k, y, exp_v.y);
            end
        end
    endtask

    task automatic test_load_hold();
        step(1'b1, 1'b1, 1'b1, 2'd1, 4'd9, 4'h0, 4'h0);
        exp_v = sb.pop_front();
        step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'h2, 4'h0);
        exp_v = sb.pop_front();
        checks++;
        if (y !== exp_v.y || y[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL jk_set y=%h want %h", y, exp_v.y);
        end
        step(1'b1, 1'b1, 1'b1, 2'd1, 4'd9, 4'h2, 4'h0);
        exp_v = sb.pop_front();
        checks++;
        if (y !== exp_v.y || y[1] !== 1'b0 || mode_q !== exp_v.mode) begin
            failures++;
            $display("[TB] FAIL reload_clear y=%h want %h mode=%h/%h", y, exp_v.y, mode_q, exp_v.mode);
        end
        step(1'b1, 1'b0, 1'b1, 2'd1, 4'd7, 4'h0, 4'h0);
        exp_v = sb.pop_front();
        checks++;
        if (mode_q !== exp_v.mode || mode_q[7:4] !== 4'd7) begin
            failures++;
            $display("[TB] FAIL load_while_disabled mode=%h want %h", mode_q, exp_v.mode);
        end
        step(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'h2, 4'h2);
        exp_v = sb.pop_front();
        checks++;
        if (y !== exp_v.y || y[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL en_hold y=%h want %h", y, exp_v.y);
        end
        step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'h2, 4'h2);
        exp_v = sb.pop_front();
        checks++;
        if (y !== exp_v.y || y[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL edge_dropped y=%h want %h", y, exp_v.y);
        end
    endtask

    task automatic test_errors();
        step(1'b1, 1'b1, 1'b1, 2'd0, 4'd12, 4'h0, 4'h0);
        exp_v = sb.pop_front();
        checks++;
        if (y !== exp_v.y || mode_q !== exp_v.mode || sel_err !== exp_v.err || sel_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bad_code err=%b/%b mode=%h/%h y=%h/%h", sel_err, exp_v.err, mode_q, exp_v.mode, y, exp_v.y);
        end
        step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'h0, 4'h0);
        exp_v = sb.pop_front();
        checks++;
        if (sel_err !== 1'b0 || mode_q !== exp_v.mode) begin
            failures++;
            $display("[TB] FAIL err_pulse_end err=%b want 0", sel_err);
        end
        sel_load3 = 1'b1;
        step(1'b1, 1'b1, 1'b0, 2'd3, 4'd1, 4'h0, 4'h0);
        sel_load3 = 1'b0;
        exp_v = sb.pop_front();
        checks++;
        if (sel_err3 !== 1'b1 || mode_q3 !== 12'h000) begin
            failures++;
            $display("[TB] FAIL bad_chan err=%b want 1 mode=%h want 000", sel_err3, mode_q3);
        end
        step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'h0, 4'h0);
        exp_v = sb.pop_front();
        checks++;
        if (sel_err3 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bad_chan_end err=%b want 0", sel_err3);
        end
    endtask

    task automatic test_reset_midrun();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'h8, 4'h8);
            exp_v = sb.pop_front();
            checks++;
            if (y !== exp_v.y) begin
                failures++;
                $display("[TB] FAIL jk_pre_reset step=%0d y=%h want %h", k, y, exp_v.y);
            end
        end
        step(1'b0, 1'b1, 1'b1, 2'd3, 4'd9, 4'h8, 4'h8);
        exp_v = sb.pop_front();
        checks++;
        if (y !== 4'h0 || mode_q !== 16'h0 || sel_err !== 1'b0 || y !== exp_v.y) begin
            failures++;
            $display("[TB] FAIL midrun_reset y=%h mode=%h err=%b want 0", y, mode_q, sel_err);
        end
        step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'hF, 4'hF);
        exp_v = sb.pop_front();
        checks++;
        if (y !== 4'hF || y !== exp_v.y) begin
            failures++;
            $display("[TB] FAIL post_reset_and y=%h want F", y);
        end
    endtask

    initial begin
        resetn = 1'b0; en = 1'b1; sel_load = 1'b0; sel_load3 = 1'b0;
        sel_chan = 2'd0; sel_code = 4'd0; a = 4'h0; b = 4'h0;
        for (int i = 0; i < 4; i++) begin
            m_mode[i] = 4'd0; m_q[i] = 1'b0; m_y[i] = 1'b0; m_bp[i] = 1'b0;
        end
        #1;
        test_reset();
        test_gate_sweep();
        test_sr_t();
        test_d_jk();
        test_load_hold();
        test_errors();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
